// File: rtl/param_reg_file_pkg.sv
// Shared types and helpers for the parametrised register file.
// Holds the clear-engine state encoding and a fallback ceil-log2 helper.
package param_reg_file_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } rf_state_t;

  // Fallback for tools without $clog2; elaboration-time use only.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/param_reg_file_sweep_ctrl.sv
// Clear-sweep controller: walks the entry index from 0 to DEPTH-1, one
// entry per cycle, after a CLR request is accepted in IDLE.
module param_reg_file_sweep_ctrl
  import param_reg_file_pkg::*;
#(
  parameter  int DEPTH  = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req_i,
  output logic              busy_o,
  output logic              clr_en_o,
  output logic [ADDR_W-1:0] clr_idx_o
);

  // Terminal count is explicit so non-power-of-2 depths stop correctly.
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  rf_state_t         state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (clr_req_i) begin
          state_d = SWEEP;
          idx_d   = '0;
        end
      end
      SWEEP: begin
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign busy_o    = (state_q == SWEEP);
  assign clr_en_o  = (state_q == SWEEP);
  assign clr_idx_o = idx_q;

endmodule

// File: rtl/param_reg_file.sv
// WIDTH x DEPTH register file with independent write/read ports, registered
// reads with a valid strobe, per-entry valid bits and a sequential clear.
module param_reg_file
  import param_reg_file_pkg::*;
#(
  parameter  int WIDTH  = 4,
  parameter  int DEPTH  = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WE,
  input  logic [ADDR_W-1:0] WA,
  input  logic [WIDTH-1:0]  Din,
  input  logic              RE,
  input  logic [ADDR_W-1:0] RA,
  output logic [WIDTH-1:0]  Dout,
  output logic              RVALID,
  output logic              RHIT,
  input  logic              CLR,
  output logic              BUSY
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  logic [WIDTH-1:0]  dout_q, dout_d;
  logic              rhit_q, rhit_d;
  logic              rvalid_q, rvalid_d;
  logic              busy;
  logic              clr_en;
  logic [ADDR_W-1:0] clr_idx;
  logic              accept, wa_ok, ra_ok, wr_en, rd_en;

  param_reg_file_sweep_ctrl #(
    .DEPTH (DEPTH)
  ) u_sweep_ctrl (
    .clk       (CLK),
    .rst       (RST),
    .clr_req_i (CLR),
    .busy_o    (busy),
    .clr_en_o  (clr_en),
    .clr_idx_o (clr_idx)
  );

  // CLR wins over a same-cycle access; nothing is accepted mid-sweep.
  assign accept = !busy && !CLR;
  assign wa_ok  = ({1'b0, WA} < DEPTH_L);
  assign ra_ok  = ({1'b0, RA} < DEPTH_L);
  assign wr_en  = accept && WE && wa_ok;
  assign rd_en  = accept && RE;

  always_comb begin
    dout_d   = dout_q;
    rhit_d   = rhit_q;
    rvalid_d = 1'b0;
    if (rd_en) begin
      rvalid_d = 1'b1;
      if (!ra_ok) begin
        dout_d = '0;
        rhit_d = 1'b0;
      end else if (wr_en && (WA == RA)) begin
        dout_d = Din;
        rhit_d = 1'b1;
      end else begin
        dout_d = mem_q[RA];
        rhit_d = vld_q[RA];
      end
    end
  end

  // NOTE: the array is reset explicitly because reads of never-written entries must return 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      vld_q <= '0;
    end else if (clr_en) begin
      mem_q[clr_idx] <= '0;
      vld_q[clr_idx] <= 1'b0;
    end else if (wr_en) begin
      mem_q[WA] <= Din;
      vld_q[WA] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      dout_q   <= '0;
      rhit_q   <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      dout_q   <= dout_d;
      rhit_q   <= rhit_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign Dout   = dout_q;
  assign RHIT   = rhit_q;
  assign RVALID = rvalid_q;
  assign BUSY   = busy;

endmodule

// File: tb/tb_param_reg_file.sv
// Scoreboard bench: a default 4x4 instance and a DEPTH=5/WIDTH=8 instance,
// each checked cycle by cycle against a behavioural model.
module tb_param_reg_file;

  typedef struct packed {
    logic [7:0] dout;
    logic       rhit;
  } rd_t;

  logic       clk;
  logic       rst4, we4, re4, clr4, rv4, rh4, busy4;
  logic [1:0] wa4, ra4;
  logic [3:0] din4, dout4;
  logic       rst5, we5, re5, clr5, rv5, rh5, busy5;
  logic [2:0] wa5, ra5;
  logic [7:0] din5, dout5;

  param_reg_file u_d4 (
    .CLK(clk), .RST(rst4), .WE(we4), .WA(wa4), .Din(din4), .RE(re4), .RA(ra4),
    .Dout(dout4), .RVALID(rv4), .RHIT(rh4), .CLR(clr4), .BUSY(busy4)
  );

  param_reg_file #(.WIDTH(8), .DEPTH(5)) u_d5 (
    .CLK(clk), .RST(rst5), .WE(we5), .WA(wa5), .Din(din5), .RE(re5), .RA(ra5),
    .Dout(dout5), .RVALID(rv5), .RHIT(rh5), .CLR(clr5), .BUSY(busy5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  rd_t  sb_q[$];

  // Behavioural model, one slot per instance (0: 4x4, 1: 5x8).
  logic [7:0] m_mem  [2][8];
  bit         m_vld  [2][8];
  bit         m_busy [2];
  int         m_idx  [2];
  logic [7:0] m_dout [2];
  bit         m_rhit [2];

  logic [7:0] o_dout;
  bit         o_rv, o_rhit, o_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input int s, input bit rst, input bit we, input int wa,
                     input logic [7:0] din, input bit re, input int ra, input bit clr);
    int         depth;
    logic [7:0] dm;
    bit         exp_rv;
    rd_t        e;
    depth = (s == 0) ? 4 : 5;
    dm    = (s == 0) ? (din & 8'h0F) : din;
    {rst4, we4, re4, clr4, wa4, ra4, din4} = '0;
    {rst5, we5, re5, clr5, wa5, ra5, din5} = '0;
    if (s == 0) begin
      rst4 = rst; we4 = we; wa4 = wa[1:0]; din4 = dm[3:0];
      re4 = re; ra4 = ra[1:0]; clr4 = clr;
    end else begin
      rst5 = rst; we5 = we; wa5 = wa[2:0]; din5 = dm;
      re5 = re; ra5 = ra[2:0]; clr5 = clr;
    end
    exp_rv = 1'b0;
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        m_mem[s][i] = '0;
        m_vld[s][i] = 1'b0;
      end
      m_busy[s] = 1'b0; m_idx[s] = 0; m_dout[s] = '0; m_rhit[s] = 1'b0;
    end else if (m_busy[s]) begin
      m_mem[s][m_idx[s]] = '0;
      m_vld[s][m_idx[s]] = 1'b0;
      m_idx[s]++;
      if (m_idx[s] == depth) begin
        m_busy[s] = 1'b0;
        m_idx[s]  = 0;
      end
    end else if (clr) begin
      m_busy[s] = 1'b1;
      m_idx[s]  = 0;
    end else begin
      if (re) begin
        exp_rv = 1'b1;
        if (ra >= depth) begin
          e.dout = '0; e.rhit = 1'b0;
        end else if (we && wa == ra) begin
          e.dout = dm; e.rhit = 1'b1;
        end else begin
          e.dout = m_mem[s][ra]; e.rhit = m_vld[s][ra];
        end
        m_dout[s] = e.dout;
        m_rhit[s] = e.rhit;
        sb_q.push_back(e);
      end
      if (we && wa < depth) begin
        m_mem[s][wa] = dm;
        m_vld[s][wa] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    o_dout = (s == 0) ? {4'h0, dout4} : dout5;
    o_rv   = (s == 0) ? rv4 : rv5;
    o_rhit = (s == 0) ? rh4 : rh5;
    o_busy = (s == 0) ? busy4 : busy5;
    check("busy", o_busy, m_busy[s]);
    check("rvalid", o_rv, exp_rv);
    if (o_rv) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("dout", o_dout, e.dout);
        check("rhit", o_rhit, e.rhit);
      end
    end else begin
      check("dout_hold", o_dout, m_dout[s]);
      check("rhit_hold", o_rhit, m_rhit[s]);
    end
  endtask

  task automatic idle(input int s);
    cyc(s, 0, 0, 0, 8'h00, 0, 0, 0);
  endtask

  int busy_cnt;

  initial begin
    {rst4, we4, re4, clr4, wa4, ra4, din4} = '0;
    {rst5, we5, re5, clr5, wa5, ra5, din5} = '0;

    // 1: write 3..0 to 0..3, back-to-back reads
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    check("reset_dout", o_dout, 0);
    check("reset_busy", o_busy, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, i, 8'(3 - i), 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0, 1, i, 0);
      check("t1_const", {o_dout, o_rhit}, {8'(3 - i), 1'b1});
    end
    idle(0);

    // 2: unwritten entry after reset, then hold
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 2, 0);
    check("t2_const", {o_rv, o_rhit}, 2'b10);
    idle(0);
    idle(0);

    // 3: write-first bypass
    cyc(0, 0, 1, 1, 8'h05, 0, 0, 0);
    cyc(0, 0, 1, 1, 8'h0A, 1, 1, 0);
    check("t3_bypass", o_dout, 8'h0A);
    cyc(0, 0, 0, 0, 0, 1, 1, 0);
    idle(0);

    // 4: DEPTH=5 fill, clear with same-cycle write, accesses while busy
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 1, i, 8'(8'h11 * (i + 1)), 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 4, 0);
    busy_cnt = 0;
    cyc(1, 0, 1, 0, 8'hFF, 0, 0, 1);
    busy_cnt += int'(o_busy);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 1, 2, 8'hAA, 1, 2, 1);
      busy_cnt += int'(o_busy);
    end
    idle(1);
    busy_cnt += int'(o_busy);
    check("t4_busy_len", busy_cnt, 5);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0, 1, i, 0);
    idle(1);

    // 5: out-of-range write and read
    cyc(1, 0, 1, 6, 8'h07, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 6, 0);
    check("t5_oor", {o_rv, o_dout, o_rhit}, {1'b1, 8'h00, 1'b0});
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0, 1, i, 0);

    // 6: reset in the third busy cycle
    for (int i = 0; i < 5; i++) cyc(1, 0, 1, i, 8'h30 + 8'(i), 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    idle(1);
    check("t6_busy_before_rst", o_busy, 1);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    check("t6_after_rst", {o_busy, o_rv, o_dout, o_rhit}, 11'h000);
    cyc(1, 0, 1, 3, 8'h09, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 3, 0);
    check("t6_readback", {o_dout, o_rhit}, {8'h09, 1'b1});
    cyc(1, 0, 0, 0, 0, 1, 4, 0);
    idle(1);

    check("sb_drain", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/param_reg_file.md
Name: param_reg_file

Overview:
Parametrised single-clock register file. It generalises the team's fixed 4-entry x 4-bit RW-multiplexed register file to WIDTH x DEPTH storage.
- Write and read ports are independent, so both can act in the same cycle.
- Reads are registered and flagged with a one-cycle valid strobe.
- Each entry carries a valid bit.
- A sequential clear engine zeroes the array one entry per cycle.
The block sits between the datapath and the control FSMs as general scratch/config storage.

Parameters:
WIDTH, 4, data bits per entry (>=1)
DEPTH, 4, number of entries (>=2; need not be a power of 2)
ADDR_W, $clog2(DEPTH), address width; derived localparam, not overridable

Ports:
CLK     in   1       clock; all state updates on rising edge
RST     in   1       synchronous, active-high reset
WE      in   1       write enable
WA      in   ADDR_W  write address
Din     in   WIDTH   write data
RE      in   1       read enable
RA      in   ADDR_W  read address
Dout    out  WIDTH   registered read data
RVALID  out  1       one-cycle strobe: Dout updated this cycle
RHIT    out  1       valid bit of the entry read; qualified by RVALID
CLR     in   1       start clear sweep (sampled only when idle)
BUSY    out  1       clear sweep in progress

Behaviour:
Reset (RST=1 at an edge):
- mem[*]=0, vld[*]=0, Dout=0, RVALID=0, RHIT=0, BUSY=0, state=IDLE, sweep_idx=0.
- Reset overrides every other input, including mid-sweep; any sweep in progress is aborted.

Write (IDLE, WE=1, CLR=0, WA<DEPTH):
- mem[WA]<=Din and vld[WA]<=1 at the edge.
- WA>=DEPTH: write is silently dropped.

Read (IDLE, RE=1, CLR=0):
- Latency 1: the edge after RE sampled, RVALID=1 for exactly one cycle.
- Dout=mem[RA], RHIT=vld[RA].
- When RE=0, RVALID=0 and Dout/RHIT hold their previous values.
- Same-cycle WE and RE with WA==RA (in range): write-first bypass. Dout=Din, RHIT=1.
- RA>=DEPTH: Dout=0, RHIT=0, RVALID=1.

FSM states IDLE, SWEEP:
- IDLE -> SWEEP: CLR=1 at an edge. sweep_idx<=0. A WE or RE in that same cycle is dropped (CLR has priority).
- SWEEP: at each edge, mem[sweep_idx]<=0, vld[sweep_idx]<=0, sweep_idx<=sweep_idx+1.
- SWEEP -> IDLE: at the edge that clears entry DEPTH-1; sweep_idx<=0.
- BUSY = (state==SWEEP). It is high for exactly DEPTH cycles, starting the cycle after CLR is sampled.
- During SWEEP, WE, RE and CLR are ignored. RVALID stays 0; Dout/RHIT hold.

Arithmetic and width:
- sweep_idx is ADDR_W bits wide.
- The terminal compare is against DEPTH-1, never against wrap-around, so non-power-of-2 DEPTH terminates correctly.
- No combinational path from any input to any output; all outputs are registered.

Decomposition:
- Package param_reg_file_pkg holds:
  - enum rf_state_t {IDLE, SWEEP}
  - a clog2 function, used only when the tool lacks $clog2
- Sub-module param_reg_file_sweep_ctrl holds the FSM, sweep_idx counter, BUSY, and the clr_en/clr_idx outputs.
- The top level holds the storage array, valid vector, write/read/bypass logic and output registers.

Test Plan:
1. Default params, reset. Write 0x3..0x0 to addresses 0..3, then read 0..3 on back-to-back cycles -> Dout 0x3,0x2,0x1,0x0 each one cycle after RE, with RVALID=1 and RHIT=1 on each read cycle.
2. After reset, read addr 2 without writing -> Dout=0, RHIT=0, RVALID=1 for one cycle. Hold RE=0 -> RVALID=0 and Dout held at 0.
3. Same cycle WE=1, WA=1, Din=0xA, RE=1, RA=1 (entry 1 holds 0x5) -> next cycle Dout=0xA, RHIT=1. A following read of addr 1 also gives 0xA.
4. DEPTH=5, WIDTH=8: fill all entries 0x11..0x55, pulse CLR with WE=1, WA=0, Din=0xFF.
   - BUSY high for exactly 5 cycles.
   - WE/RE during BUSY have no effect and RVALID stays 0.
   - Afterwards every read returns Dout=0, RHIT=0; the same-cycle write to addr 0 was dropped.
5. DEPTH=5: write addr 6, Din=0x7 -> no entry changes. Read addr 6 -> Dout=0, RHIT=0, RVALID=1.
6. Assert RST on the 3rd BUSY cycle of a sweep -> next cycle BUSY=0, all outputs 0. A write then read of addr 3 with 0x9 returns 0x9, RHIT=1.
